// File: rtl/mux_stream_rr_if.sv
// mux_stream_rr_if: valid/ready bundle between N producers, the stream mux and one consumer
interface mux_stream_rr_if #(
  parameter int N_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W = $clog2(N_CH)
);
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_ch;
  logic                   out_ready;
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/mux_stream_rr.sv
// mux_stream_rr: N-channel valid/ready stream mux, fixed-select or round-robin grant,
// winning beat captured into a one-deep output register
module mux_stream_rr #(
  parameter int N_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input logic            clk,
  input logic            rst_n,
  mux_stream_rr_if.slave s
);
  localparam logic [SEL_W:0] NC = (SEL_W+1)'(N_CH);
  logic [SEL_W-1:0]    ptr, off, rr_gnt, gnt;
  logic [SEL_W:0]      sum, wrap;
  logic [N_CH-1:0]     rot;
  logic [2**SEL_W-1:0] vpad;
  logic                load_en, gnt_vld, xfer;
  // rotate valids so bit 0 is the channel at ptr, then take the lowest set offset
  always_comb begin
    rot = (N_CH)'({s.in_valid, s.in_valid} >> ptr);
    off = '0;
    for (int k = N_CH-1; k >= 0; k--) off = rot[k] ? SEL_W'(k) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    wrap = sum >= NC ? sum - NC : sum;
    rr_gnt = wrap[SEL_W-1:0];
  end
  assign vpad = (2**SEL_W)'(s.in_valid);
  assign load_en = !s.out_valid || s.out_ready;
  assign gnt = s.mode ? rr_gnt : s.sel;
  assign gnt_vld = s.mode ? |s.in_valid : ({1'b0, s.sel} < NC) && vpad[s.sel];
  assign xfer = rst_n && load_en && gnt_vld;
  assign s.in_ready = xfer ? {{(N_CH-1){1'b0}}, 1'b1} << gnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.out_valid <= 1'b0;
      s.out_data <= '0;
      s.out_ch <= '0;
      ptr <= '0;
    end else if (load_en) begin
      s.out_valid <= gnt_vld;
      if (gnt_vld) begin
        s.out_data <= s.in_data[gnt*DATA_W +: DATA_W];
        s.out_ch <= gnt;
        ptr <= gnt == SEL_W'(N_CH-1) ? '0 : gnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/mux_stream_rr.md
# mux_stream_rr

Parametrised N-channel, W-bit stream multiplexer; the registered, handshaked successor to the fixed 4:1 bit mux. It selects one of N_CH valid/ready input streams, either by an external select or by round-robin arbitration. The winning beat is captured into a one-deep output register. It sits between multiple producers and a single downstream consumer, and supports full throughput (one beat per cycle).

## Interface
- N_CH, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel.
- SEL_W, $clog2(N_CH), width of `sel` and `out_ch`.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- mode  in  1  arbitration mode:
  - 0: fixed select via `sel`.
  - 1: round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- in_valid  in  N_CH  per-channel valid.
- in_data  in  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_ready  out  N_CH  per-channel ready; at most one bit high per cycle.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_W  registered data.
- out_ch  out  SEL_W  index of the channel that produced out_data.
- out_ready  in  1  downstream ready.

## Operation
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_en = !out_valid | out_ready. The register accepts a new beat when empty or when draining in the same cycle.
- Grant (combinational):
  - mode=0: gnt = sel, gnt_vld = in_valid[sel] when sel < N_CH; otherwise gnt_vld=0 (out-of-range select grants nothing).
  - mode=1: gnt = first k with in_valid[k]=1, scanning ptr, ptr+1, ..., wrapping modulo N_CH. gnt_vld = |in_valid.
- in_ready[gnt] = load_en & gnt_vld; all other in_ready bits are 0. Transfer on channel k occurs when in_valid[k] & in_ready[k].
- On transfer: out_data ← in_data[gnt], out_ch ← gnt, out_valid ← 1.
- If load_en and no transfer: out_valid ← 0 when out_ready drained the register; otherwise it holds 0. out_data and out_ch hold their last values.
- If FULL and out_ready=0: all outputs hold; in_ready = 0.
- Round-robin pointer ptr (SEL_W bits):
  - On every transfer (either mode), ptr ← gnt+1, wrapping N_CH-1 → 0.
  - Otherwise ptr holds.
  - ptr is not reset by mode changes.
- mode and sel are sampled combinationally each cycle. A change affects the grant in the same cycle and never alters a beat already in the output register.
- Reset mid-operation: any held beat is discarded immediately. No input beat is accepted while rst_n=0 (in_ready=0).
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=0.

## Timing
- Latency: 1 cycle from input transfer (edge n) to out_valid/out_data visible after edge n.
- Throughput: 1 beat/cycle when out_ready=1 continuously.
- in_ready depends combinationally on out_ready, mode, sel and in_valid. There is no combinational path from in_data to any output.
- Producers must hold in_valid/in_data stable until their transfer. Dropping valid before the transfer is permitted and simply re-arbitrates.
- Simultaneous drain and load in one cycle is a normal transfer: out_valid stays 1 and the data is replaced.
- Fairness in mode=1: with all channels continuously valid and out_ready=1, the grant sequence is 0,1,...,N_CH-1,0,... Any valid channel is served within N_CH transfers.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n=0 with in_valid=4'b1111.
  - Required: out_valid=0, out_data=0, out_ch=0, in_ready=0.
  - After release with out_ready=1: first transfer is from ch0 in mode=1.
- Fixed select:
  - Stimulus: mode=0, sel=2, in_valid=4'b0101, ch2 data 8'hA5, out_ready=1.
  - Required: in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_ch=2.
  - With sel=1 and in_valid[1]=0: no transfer, out_valid falls to 0.
- Round-robin fairness:
  - Stimulus: mode=1, all valid, per-channel data = channel id, out_ready=1 for 8 cycles.
  - Required: out_ch sequence 0,1,2,3,0,1,2,3, one beat per cycle.
- Sparse round-robin wrap:
  - Stimulus: after a ch3 transfer (ptr=0), in_valid=4'b0100.
  - Required: ch2 granted; ptr becomes 3; a following in_valid=4'b1001 grants ch3 before ch0.
- Backpressure:
  - Stimulus: out_ready=0 while FULL with out_data=3C; producers toggle their data.
  - Required: out_data stays 3C and in_ready=0.
  - On the out_ready rising cycle: drain and new load happen together, no bubble and no beat lost.
- Reset mid-stream:
  - Stimulus: drop rst_n asynchronously while FULL, between clock edges.
  - Required: out_valid goes to 0 immediately, ptr=0, no in_ready during reset.
